vga_fb_fetch_arbiter: RTL

//  Shares one single-outstanding framebuffer memory port between display line prefetch and a pixel writer (drawing engine).

---
 rtl/vga_fb_fetch_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vga_fb_fetch_arbiter.sv
// rtl/vga_fb_fetch_arbiter.sv - framebuffer port arbiter: display line prefetch vs pixel writer
// Ports:
//   clk, reset                 pixel clock, synchronous active-high reset
//   enable                     arms line prefetch triggers
//   fb_base                    frame base word address (reloaded at line 0)
//   x_idx, y_idx               scan counters from the sync controllers
//   wr_req/wr_addr/wr_data     writer request, held until wr_done
//   wr_done                    1-cycle writer completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata
//                              single-outstanding memory port
//   lb_we/lb_bank/lb_waddr/lb_wdata
//                              ping-pong line buffer write port
//   underrun                   sticky: a prefetch missed its line deadline
module vga_fb_fetch_arbiter #(
  parameter int PIXELS_H     = 1920,
  parameter int PIXELS_V     = 1080,
  parameter int V_TOTAL      = 1125,
  parameter int PIX_PER_WORD = 4,
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 48,
  parameter int WR_MAX_WAIT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [11:0]       x_idx,
  input  logic [11:0]       y_idx,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [8:0]        lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              underrun
);

  localparam int WORDS  = PIXELS_H / PIX_PER_WORD;
  localparam int WAIT_W = $clog2(WR_MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t            state;
  logic [11:0]       prev_x;
  logic              fetch_pending;
  logic              discard;      // in-flight read belongs to an abandoned line
  logic [8:0]        word;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] base_acc;     // base of the most recent target line, tracked even when disabled
  logic              tgt_bank;
  logic [WAIT_W-1:0] wait_cnt;

  logic              has_target;
  logic [11:0]       target;
  logic              trig;
  logic              trig_accept;
  logic [ADDR_W-1:0] next_base;
  logic              wr_starved;
  logic              grant_write;
  logic              grant_fetch;

  always_comb begin
    has_target = 1'b0;
    target     = '0;
    if (y_idx < 12'(PIXELS_V - 1)) begin
      has_target = 1'b1;
      target     = y_idx + 12'd1;
    end else if (y_idx == 12'(V_TOTAL - 1)) begin
      has_target = 1'b1;
    end
  end

  assign trig        = (x_idx == 12'd0) && (prev_x != 12'd0) && has_target;
  assign trig_accept = trig && enable;
  assign next_base   = (target == 12'd0) ? fb_base : base_acc + ADDR_W'(WORDS);
  assign wr_starved  = (wait_cnt >= WAIT_W'(WR_MAX_WAIT));
  // A trigger cycle never grants: the fetch address would still be the old line's.
  assign grant_write = (state == IDLE) && !trig_accept && wr_req && (!fetch_pending || wr_starved);
  assign grant_fetch = (state == IDLE) && !trig_accept && !grant_write && fetch_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      prev_x        <= '0;
      fetch_pending <= 1'b0;
      discard       <= 1'b0;
      word          <= '0;
      line_base     <= '0;
      base_acc      <= '0;
      tgt_bank      <= 1'b0;
      wait_cnt      <= '0;
      wr_done       <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      lb_we         <= 1'b0;
      lb_bank       <= 1'b0;
      lb_waddr      <= '0;
      lb_wdata      <= '0;
      underrun      <= 1'b0;
    end else begin
      prev_x  <= x_idx;
      lb_we   <= 1'b0;
      wr_done <= 1'b0;

      if (trig) base_acc <= next_base;

      if (wr_req && (state != WRITE) && !grant_write && !wr_starved)
        wait_cnt <= wait_cnt + WAIT_W'(1);

      if (trig_accept) begin
        if (fetch_pending) underrun <= 1'b1;
        fetch_pending <= 1'b1;
        word          <= '0;
        line_base     <= next_base;
        tgt_bank      <= target[0];
      end

      case (state)
        IDLE: begin
          if (grant_write) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
          end else if (grant_fetch) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= line_base + ADDR_W'(word);
          end
        end
        FETCH: begin
          if (trig_accept && !mem_ack) discard <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            discard <= 1'b0;
            if (!discard && !trig_accept) begin
              lb_we    <= 1'b1;
              lb_bank  <= tgt_bank;
              lb_waddr <= word;
              lb_wdata <= mem_rdata;
              word     <= word + 9'd1;
              if (word == 9'(WORDS - 1)) fetch_pending <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            state    <= IDLE;
            wr_done  <= 1'b1;
            wait_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
